// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, taken-branch flushes,
// memory freezes, plus saturating debug counters and a sticky memory-timeout flag.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_register_rs1,
    input  logic [4:0]       if_id_register_rs2,
    input  logic [4:0]       id_ex_register_rd,
    input  logic             id_ex_memread,
    input  logic [9:0]       id_control_in,
    input  logic             branch_taken,
    input  logic             ex_mem_mem_op,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic [9:0]       id_ex_control,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      cur_state;
    logic [3:0]  fcnt;
    logic [15:0] wcnt;
    logic [15:0] wcnt_inc;
    logic        freeze;
    logic        load_use;
    logic        in_flush;
    logic        take_branch;
    logic        do_stall;

    assign freeze   = ex_mem_mem_op & ~dmem_ready;
    assign load_use = id_ex_memread & (id_ex_register_rd != 5'd0) &
                      ((id_ex_register_rd == if_id_register_rs1) |
                       (id_ex_register_rd == if_id_register_rs2));
    assign in_flush = (cur_state == FLUSH);

    // While flushing, EX holds a bubble, so branch and load-use inputs are stale.
    assign take_branch = ~freeze & ~in_flush & branch_taken;
    assign do_stall    = ~freeze & ~in_flush & ~branch_taken & load_use;
    assign wcnt_inc    = (wcnt != 16'hFFFF) ? wcnt + 16'd1 : wcnt;
    assign state       = cur_state;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_control = id_control_in;
        pipe_hold     = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b0;
            id_ex_control = 10'd0;
            pipe_hold     = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (in_flush || take_branch) begin
            if_id_flush   = 1'b1;
            id_ex_control = 10'd0;
        end else if (do_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_control = 10'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= RUN;
            fcnt         <= 4'd0;
            wcnt         <= 16'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            if (freeze) begin
                wcnt <= wcnt_inc;
                if (wcnt_inc >= TIMEOUT_VAL)
                    mem_timeout <= 1'b1;
            end else begin
                wcnt <= 16'd0;
            end

            if ((freeze || do_stall) && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (take_branch && flush_count != '1)
                flush_count <= flush_count + 1'b1;

            case (cur_state)
                RUN, MEM_WAIT: begin
                    if (freeze) begin
                        cur_state <= MEM_WAIT;
                    end else if (branch_taken && FLUSH_CYCLES > 1) begin
                        cur_state <= FLUSH;
                        fcnt      <= FLUSH_LOAD;
                    end else begin
                        cur_state <= RUN;
                    end
                end
                FLUSH: begin
                    if (!freeze) begin
                        if (fcnt <= 4'd1) begin
                            cur_state <= RUN;
                            fcnt      <= 4'd0;
                        end else begin
                            fcnt <= fcnt - 4'd1;
                        end
                    end
                end
                default: cur_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=8) using a
// per-cycle scoreboard of expected control outputs.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  if_id_register_rs1;
    logic [4:0]  if_id_register_rs2;
    logic [4:0]  id_ex_register_rd;
    logic        id_ex_memread;
    logic [9:0]  id_control_in;
    logic        branch_taken;
    logic        ex_mem_mem_op;
    logic        dmem_ready;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_write;
    logic [9:0]  id_ex_control;
    logic        pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic        mem_timeout;

    int checks;
    int failures;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       memread;
        logic [9:0] ctrl;
        logic       branch;
        logic       mem_op;
        logic       ready;
    } stim_t;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, pipe_hold, state, id_ex_control}
    logic [16:0] obs;
    logic [16:0] sb_q[$];

    assign obs = {pc_write, if_id_write, if_id_flush, id_ex_write, pipe_hold, state, id_ex_control};

    hazard_ctrl #(
        .FLUSH_CYCLES(3),
        .MEM_TIMEOUT (8),
        .CNT_W       (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_id_register_rs1(if_id_register_rs1),
        .if_id_register_rs2(if_id_register_rs2),
        .id_ex_register_rd (id_ex_register_rd),
        .id_ex_memread     (id_ex_memread),
        .id_control_in     (id_control_in),
        .branch_taken      (branch_taken),
        .ex_mem_mem_op     (ex_mem_mem_op),
        .dmem_ready        (dmem_ready),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_write       (id_ex_write),
        .id_ex_control     (id_ex_control),
        .pipe_hold         (pipe_hold),
        .state             (state),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count),
        .mem_timeout       (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    function automatic stim_t mk_stim(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic memread,
                                      input logic [9:0] ctrl, input logic branch,
                                      input logic mem_op, input logic ready);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.memread = memread;
        s.ctrl = ctrl; s.branch = branch; s.mem_op = mem_op; s.ready = ready;
        return s;
    endfunction

    function automatic logic [16:0] mk_exp(input logic pc, input logic ifw, input logic fl,
                                           input logic idw, input logic hold,
                                           input logic [1:0] st, input logic [9:0] ctrl);
        return {pc, ifw, fl, idw, hold, st, ctrl};
    endfunction

    task automatic drive(input stim_t s, input logic [16:0] e);
        if_id_register_rs1 = s.rs1;
        if_id_register_rs2 = s.rs2;
        id_ex_register_rd  = s.rd;
        id_ex_memread      = s.memread;
        id_control_in      = s.ctrl;
        branch_taken       = s.branch;
        ex_mem_mem_op      = s.mem_op;
        dmem_ready         = s.ready;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(mk_stim(0, 0, 0, 0, 10'h000, 0, 0, 1), 17'd0);
        void'(sb_q.pop_front());
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst_n = 1'b0;
        drive(mk_stim(5, 5, 5, 1, 10'h3FF, 1, 0, 1), mk_exp(0, 0, 1, 0, 1, 2'd0, 10'h000));
        @(negedge clk);
        got = sb_q.pop_front();
        checks++;
        if (obs !== got) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h want=%h", obs, got);
        end
        checks++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0 || mem_timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_counters got=%0d/%0d/%b want=0/0/0",
                     stall_cycles, flush_count, mem_timeout);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t s[3];
        logic [16:0] e[3];
        logic [16:0] got;
        reset_dut();
        s[0] = mk_stim(5, 0, 5, 1, 10'h0A3, 0, 0, 1); e[0] = mk_exp(0, 0, 0, 1, 0, 2'd0, 10'h000);
        s[1] = mk_stim(5, 0, 5, 0, 10'h0A3, 0, 0, 1); e[1] = mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h0A3);
        s[2] = mk_stim(3, 9, 9, 1, 10'h011, 0, 0, 1); e[2] = mk_exp(0, 0, 0, 1, 0, 2'd0, 10'h000);
        for (int i = 0; i < 3; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs !== got) begin
                failures++;
                $display("[TB] FAIL load_use[%0d] got=%h want=%h", i, obs, got);
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 16'd2) begin
            failures++;
            $display("[TB] FAIL load_use_stalls got=%0d want=2", stall_cycles);
        end
    endtask

    task automatic test_x0_exclusion();
        stim_t s[2];
        logic [16:0] e[2];
        logic [16:0] got;
        reset_dut();
        s[0] = mk_stim(3, 0, 0, 1, 10'h155, 0, 0, 1); e[0] = mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h155);
        s[1] = mk_stim(3, 4, 7, 1, 10'h2AA, 0, 0, 1); e[1] = mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h2AA);
        for (int i = 0; i < 2; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs !== got) begin
                failures++;
                $display("[TB] FAIL x0_exclusion[%0d] got=%h want=%h", i, obs, got);
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            failures++;
            $display("[TB] FAIL x0_stalls got=%0d want=0", stall_cycles);
        end
    endtask

    task automatic test_branch();
        stim_t s[4];
        logic [16:0] e[4];
        logic [16:0] got;
        reset_dut();
        // Branch coincides with a load-use hazard; the branch must win.
        s[0] = mk_stim(5, 0, 5, 1, 10'h2AA, 1, 0, 1); e[0] = mk_exp(1, 1, 1, 1, 0, 2'd0, 10'h000);
        s[1] = mk_stim(5, 0, 5, 1, 10'h2AA, 1, 0, 1); e[1] = mk_exp(1, 1, 1, 1, 0, 2'd2, 10'h000);
        s[2] = mk_stim(0, 0, 0, 0, 10'h2AA, 0, 0, 1); e[2] = mk_exp(1, 1, 1, 1, 0, 2'd2, 10'h000);
        s[3] = mk_stim(0, 0, 0, 0, 10'h2AA, 0, 0, 1); e[3] = mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h2AA);
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs !== got) begin
                failures++;
                $display("[TB] FAIL branch[%0d] got=%h want=%h", i, obs, got);
            end
            tick();
        end
        checks++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin
            failures++;
            $display("[TB] FAIL branch_counters got=%0d/%0d want=1/0", flush_count, stall_cycles);
        end
    endtask

    task automatic test_flush_freeze();
        stim_t s[5];
        logic [16:0] e[5];
        logic [16:0] got;
        reset_dut();
        s[0] = mk_stim(0, 0, 0, 0, 10'h0F0, 1, 0, 1); e[0] = mk_exp(1, 1, 1, 1, 0, 2'd0, 10'h000);
        s[1] = mk_stim(0, 0, 0, 0, 10'h0F0, 0, 1, 0); e[1] = mk_exp(0, 0, 0, 0, 1, 2'd2, 10'h0F0);
        s[2] = mk_stim(0, 0, 0, 0, 10'h0F0, 0, 1, 1); e[2] = mk_exp(1, 1, 1, 1, 0, 2'd2, 10'h000);
        s[3] = mk_stim(0, 0, 0, 0, 10'h0F0, 0, 0, 1); e[3] = mk_exp(1, 1, 1, 1, 0, 2'd2, 10'h000);
        s[4] = mk_stim(0, 0, 0, 0, 10'h0F0, 0, 0, 1); e[4] = mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h0F0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs !== got) begin
                failures++;
                $display("[TB] FAIL flush_freeze[%0d] got=%h want=%h", i, obs, got);
            end
            tick();
        end
        checks++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd1) begin
            failures++;
            $display("[TB] FAIL flush_freeze_counters got=%0d/%0d want=1/1", flush_count, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        logic [16:0] got;
        logic [16:0] e;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                e = mk_exp(0, 0, 0, 0, 1, (i == 0) ? 2'd0 : 2'd1, 10'h1C3);
                drive(mk_stim(0, 0, 0, 0, 10'h1C3, 1, 1, 0), e);
            end else if (i == 4) begin
                drive(mk_stim(0, 0, 0, 0, 10'h1C3, 1, 1, 1), mk_exp(1, 1, 1, 1, 0, 2'd1, 10'h000));
            end else if (i < 7) begin
                drive(mk_stim(0, 0, 0, 0, 10'h1C3, 0, 0, 1), mk_exp(1, 1, 1, 1, 0, 2'd2, 10'h000));
            end else begin
                drive(mk_stim(0, 0, 0, 0, 10'h1C3, 0, 0, 1), mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h1C3));
            end
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs !== got) begin
                failures++;
                $display("[TB] FAIL mem_wait[%0d] got=%h want=%h", i, obs, got);
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 16'd4 || flush_count !== 16'd1 || mem_timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mem_wait_counters got=%0d/%0d/%b want=4/1/0",
                     stall_cycles, flush_count, mem_timeout);
        end
    endtask

    task automatic test_timeout();
        logic [16:0] got;
        logic        want_to;
        reset_dut();
        for (int k = 1; k <= 10; k++) begin
            drive(mk_stim(0, 0, 0, 0, 10'h077, 0, 1, 0),
                  mk_exp(0, 0, 0, 0, 1, (k == 1) ? 2'd0 : 2'd1, 10'h077));
            @(negedge clk);
            got = sb_q.pop_front();
            checks++;
            if (obs !== got) begin
                failures++;
                $display("[TB] FAIL timeout_freeze[%0d] got=%h want=%h", k, obs, got);
            end
            tick();
            want_to = (k >= 8);
            checks++;
            if (mem_timeout !== want_to) begin
                failures++;
                $display("[TB] FAIL timeout_flag[%0d] got=%b want=%b", k, mem_timeout, want_to);
            end
        end
        drive(mk_stim(0, 0, 0, 0, 10'h077, 0, 1, 1), mk_exp(1, 1, 0, 1, 0, 2'd1, 10'h077));
        @(negedge clk);
        got = sb_q.pop_front();
        checks++;
        if (obs !== got) begin
            failures++;
            $display("[TB] FAIL timeout_release got=%h want=%h", obs, got);
        end
        tick();
        checks++;
        if (mem_timeout !== 1'b1 || stall_cycles !== 16'd10 || state !== 2'd0) begin
            failures++;
            $display("[TB] FAIL timeout_after got=%b/%0d/%0d want=1/10/0",
                     mem_timeout, stall_cycles, state);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [16:0] got;
        reset_dut();
        drive(mk_stim(0, 0, 0, 0, 10'h0F0, 1, 0, 1), mk_exp(1, 1, 1, 1, 0, 2'd0, 10'h000));
        @(negedge clk);
        got = sb_q.pop_front();
        checks++;
        if (obs !== got) begin
            failures++;
            $display("[TB] FAIL mid_reset_branch got=%h want=%h", obs, got);
        end
        tick();
        drive(mk_stim(0, 0, 0, 0, 10'h0F0, 0, 0, 1), mk_exp(0, 0, 1, 0, 1, 2'd0, 10'h000));
        #2;
        rst_n = 1'b0;
        #1;
        got = sb_q.pop_front();
        checks++;
        if (obs !== got) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs got=%h want=%h", obs, got);
        end
        checks++;
        if (flush_count !== 16'd0 || stall_cycles !== 16'd0 || mem_timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_counters got=%0d/%0d/%b want=0/0/0",
                     flush_count, stall_cycles, mem_timeout);
        end
        tick();
        rst_n = 1'b1;
        drive(mk_stim(0, 0, 0, 0, 10'h0F0, 0, 0, 1), mk_exp(1, 1, 0, 1, 0, 2'd0, 10'h0F0));
        @(negedge clk);
        got = sb_q.pop_front();
        checks++;
        if (obs !== got) begin
            failures++;
            $display("[TB] FAIL mid_reset_resume got=%h want=%h", obs, got);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        if_id_register_rs1 = 5'd0;
        if_id_register_rs2 = 5'd0;
        id_ex_register_rd  = 5'd0;
        id_ex_memread      = 1'b0;
        id_control_in      = 10'd0;
        branch_taken       = 1'b0;
        ex_mem_mem_op      = 1'b0;
        dmem_ready         = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_x0_exclusion();
        test_branch();
        test_flush_freeze();
        test_mem_wait();
        test_timeout();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sequences the IF/ID and ID/EX pipeline registers and the downstream pipeline:
- inserts load-use bubbles into the 10-bit ID/EX control word;
- flushes wrong-path instructions on taken branches, optionally for several cycles;
- freezes the whole pipeline while the data memory is busy.

It also keeps saturating stall and flush counters and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- FLUSH_CYCLES, 1: bubble cycles per taken branch. Legal range is 1..15.
- MEM_TIMEOUT, 255: number of consecutive freeze cycles before mem_timeout is set. Legal range is 1..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_id_register_rs1  in  5  rs1 field of the instruction in ID.
- if_id_register_rs2  in  5  rs2 field of the instruction in ID.
- id_ex_register_rd  in  5  rd of the instruction in EX.
- id_ex_memread  in  1  the instruction in EX is a load.
- id_control_in  in  10  decoded control word. Bit map: [9] memtoreg, [8] alusrc, [7] memread, [6] memwrite, [5] branch, [4] regwrite, [3:0] alu_control.
- branch_taken  in  1  branch in EX resolved taken.
- ex_mem_mem_op  in  1  the instruction in MEM performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clears to a NOP on this edge.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_control  out  10  control word presented to ID/EX. Equals id_control_in, or 0 when bubbling.
- pipe_hold  out  1  hold EX/MEM and MEM/WB.
- state  out  2  current state: 0 RUN, 1 MEM_WAIT, 2 FLUSH.
- stall_cycles  out  CNT_W  saturating count of stall and freeze cycles.
- flush_count  out  CNT_W  saturating count of accepted taken branches.
- mem_timeout  out  1  sticky flag: a freeze has lasted MEM_TIMEOUT cycles.

## Operation
Definitions:
- freeze = ex_mem_mem_op & ~dmem_ready.
- load_use = id_ex_memread & (id_ex_register_rd != 0) & (id_ex_register_rd == rs1 | id_ex_register_rd == rs2).
- Outputs are combinational from state and inputs. The counters, the FSM and mem_timeout are registered.

Action priority each cycle: freeze > branch > load_use > normal.
- **Freeze:** pc_write, if_id_write and id_ex_write = 0; pipe_hold = 1; if_id_flush = 0; id_ex_control = id_control_in.
- **Branch:** applies only in RUN or MEM_WAIT.
  - pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_write = 1, id_ex_control = 0.
  - flush_count increments.
- **Load_use:** pc_write = 0, if_id_write = 0, id_ex_write = 1, id_ex_control = 0, pipe_hold = 0.
- **Normal:** all enables 1, pipe_hold = 0, if_id_flush = 0, id_ex_control = id_control_in.

FSM:
- **RUN:**
  - freeze → MEM_WAIT.
  - branch with FLUSH_CYCLES > 1 → FLUSH, loading fcnt = FLUSH_CYCLES-1.
  - Otherwise stay in RUN. A load-use stall lasts exactly one cycle because the load leaves EX, so no dedicated state is needed.
- **MEM_WAIT:**
  - While freeze holds, stay.
  - On the first cycle freeze is low, apply the RUN decision rules in that same cycle, including the transitions.
- **FLUSH:**
  - Each non-frozen cycle: pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_write = 1, id_ex_control = 0; fcnt decrements; fcnt == 1 → RUN.
  - A freeze inside FLUSH holds fcnt and stays in FLUSH.
  - branch_taken and load_use are ignored, because EX holds a bubble.

Counters:
- stall_cycles increments on every freeze or load_use cycle and saturates at all-ones. FLUSH bubbles are not counted.
- wcnt (internal, 16 bit) counts consecutive freeze cycles and clears on any non-freeze cycle. When wcnt reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset. The pipeline keeps waiting.

Reset:
- While rst_n is low: state = RUN, fcnt, wcnt and both counters = 0, mem_timeout = 0.
- Also while rst_n is low the outputs are forced: pc_write, if_id_write and id_ex_write = 0; if_id_flush = 1; pipe_hold = 1; id_ex_control = 0.
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts the operation immediately.

## Timing
- Zero-cycle latency from inputs to control outputs; decisions take effect on the same rising edge.
- A load-use stall costs 1 cycle. A taken branch costs FLUSH_CYCLES bubbles.
- Freeze lasts exactly the number of cycles dmem_ready stays low while ex_mem_mem_op = 1.
- After rst_n deasserts, the first edge applies normal behaviour.
- Simultaneous events:
  - Freeze together with branch_taken: freeze wins and the branch is re-evaluated on release; flush_count increments once.
  - branch_taken together with load_use: the branch wins and no stall is counted.

## Test plan
- **Load-use:** id_ex_memread = 1, rd = 5, rs1 = 5, ctrl = 10'h0A3 → one cycle with pc_write = 0, if_id_write = 0, id_ex_control = 0; stall_cycles = 1; the next cycle passes 10'h0A3.
- **x0 exclusion:** rd = 0 = rs2 with memread = 1 → no stall; all enables 1.
- **Branch with FLUSH_CYCLES = 3:** branch_taken pulse → 3 consecutive cycles with if_id_flush = 1 and id_ex_control = 0; state sequence RUN, FLUSH, FLUSH, RUN; flush_count = 1.
- **Memory wait:** ex_mem_mem_op = 1, dmem_ready low for 4 cycles, branch_taken also high → 4 freeze cycles, then the branch flush; stall_cycles = 4; flush_count = 1.
- **Timeout:** MEM_TIMEOUT = 8, dmem_ready low for 10 cycles → mem_timeout rises after the 8th freeze cycle and stays at 1 after release; stall_cycles = 10.
- **Reset mid-operation:** rst_n low during FLUSH with fcnt = 2 → outputs forced to reset values immediately; state = 0; counters = 0.
